// File: rtl/multi_timer_pkg.sv
// Shared definitions for the multi_timer channel array: register map,
// CTRL bit layout and the oscillator-1 prescale tap widths.
package multi_timer_pkg;

    // Byte offsets inside one 8-byte channel window
    localparam logic [2:0] OFS_CTRL   = 3'd0;
    localparam logic [2:0] OFS_STATUS = 3'd1;
    localparam logic [2:0] OFS_PRE_L  = 3'd2;
    localparam logic [2:0] OFS_PRE_H  = 3'd3;
    localparam logic [2:0] OFS_CMP_L  = 3'd4;
    localparam logic [2:0] OFS_CMP_H  = 3'd5;
    localparam logic [2:0] OFS_CNT_L  = 3'd6;
    localparam logic [2:0] OFS_CNT_H  = 3'd7;

    // CTRL bit positions
    localparam int unsigned CTRL_ENABLE       = 0;
    localparam int unsigned CTRL_RELOAD       = 1;
    localparam int unsigned CTRL_OSC_SEL      = 2;
    localparam int unsigned CTRL_ONE_SHOT     = 3;
    localparam int unsigned CTRL_CHAIN        = 4;
    localparam int unsigned CTRL_PRESCALE_LSB = 5;

    typedef struct packed {
        logic [2:0] prescale;
        logic       chain;
        logic       one_shot;
        logic       osc_sel;
        logic       reload;
        logic       enable;
    } tmr_ctrl_t;

    // Number of low oscillator-1 bits that must be all ones for prescale 0..7
    localparam int unsigned OSC1_WIDTH [8] = '{1, 3, 5, 6, 7, 8, 10, 12};

endpackage

// File: rtl/multi_timer_prescaler.sv
// Shared oscillator counters for the timer array. Produces one tick vector
// per oscillator, indexed by the channel prescale field.
module multi_timer_prescaler
    import multi_timer_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       clk_ce,
    input  logic       rt_tick,
    output logic [7:0] tick_osc1,
    output logic [7:0] tick_osc2
);

    logic [11:0] osc1_q;
    logic [6:0]  osc2_q;

    // Free-running oscillator counters; both wrap silently
    always_ff @(posedge clk) begin
        if (reset) begin
            osc1_q <= '0;
            osc2_q <= '0;
        end else begin
            if (clk_ce) begin
                osc1_q <= osc1_q + 12'd1;
            end
            if (rt_tick) begin
                osc2_q <= osc2_q + 7'd1;
            end
        end
    end

    for (genvar p = 0; p < 8; p++) begin : g_tick
        localparam int unsigned K = OSC1_WIDTH[p];
        assign tick_osc1[p] = clk_ce & (&osc1_q[K-1:0]);
        if (p == 0) begin : g_p0
            assign tick_osc2[p] = rt_tick;
        end else begin : g_pn
            assign tick_osc2[p] = rt_tick & (&osc2_q[p-1:0]);
        end
    end

endmodule

// File: rtl/multi_timer.sv
// N-channel down-counting timer array on the CPU byte bus.
// Optional feature: define MULTI_TIMER_SNAPSHOT_EN to latch COUNT H when
// COUNT L is read, so a L-then-H read pair is coherent.
module multi_timer
    import multi_timer_pkg::*;
#(
    parameter int unsigned NUM_CH    = 3,
    parameter int unsigned CNT_W     = 16,
    parameter logic [23:0] BASE_ADDR = 24'h002030
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clk_ce,
    input  logic              clk_ce_cpu,
    input  logic              rt_tick,
    input  logic              bus_write,
    input  logic              bus_read,
    input  logic [23:0]       bus_address_in,
    input  logic [7:0]        bus_data_in,
    output logic [7:0]        bus_data_out,
    output logic [NUM_CH-1:0] irq_underflow,
    output logic [NUM_CH-1:0] irq_compare,
    output logic [NUM_CH-1:0] tout
);

    logic [7:0]        tick_osc1, tick_osc2;
    logic [23:0]       rel_addr;
    logic              in_range, wr_en;
    logic [2:0]        ch_sel, ofs;
    logic              unused_addr_hi;
    logic [NUM_CH-1:0] base_tick, chain_sel, active, cnt_zero, tick_ev, uf_ev;
    logic [7:0]        rdata [NUM_CH];

    multi_timer_prescaler u_prescaler (
        .clk       (clk),
        .reset     (reset),
        .clk_ce    (clk_ce),
        .rt_tick   (rt_tick),
        .tick_osc1 (tick_osc1),
        .tick_osc2 (tick_osc2)
    );

    assign rel_addr       = bus_address_in - BASE_ADDR;
    assign in_range       = (bus_address_in >= BASE_ADDR) && (rel_addr < 24'(8 * NUM_CH));
    assign ch_sel         = rel_addr[5:3];
    assign ofs            = rel_addr[2:0];
    assign wr_en          = clk_ce_cpu && bus_write && in_range;
    assign unused_addr_hi = ^rel_addr[23:6];

`ifdef MULTI_TIMER_SNAPSHOT_EN
    logic rd_en;
    assign rd_en = clk_ce_cpu && bus_read && in_range;
`else
    logic unused_bus_read;
    assign unused_bus_read = bus_read;
`endif

    // Resolve ticks in channel order so a chained underflow ripples within one cycle
    always_comb begin
        tick_ev    = '0;
        uf_ev      = '0;
        tick_ev[0] = base_tick[0] && active[0] && !chain_sel[0];
        uf_ev[0]   = tick_ev[0] && cnt_zero[0];
        for (int i = 1; i < NUM_CH; i++) begin
            tick_ev[i] = (chain_sel[i] ? uf_ev[i-1] : base_tick[i]) && active[i];
            uf_ev[i]   = tick_ev[i] && cnt_zero[i];
        end
    end

    // Read mux; misses return 0
    always_comb begin
        bus_data_out = 8'h00;
        for (int i = 0; i < NUM_CH; i++) begin
            if (in_range && (ch_sel == 3'(i))) begin
                bus_data_out = rdata[i];
            end
        end
    end

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
        tmr_ctrl_t        ctrl_q, ctrl_d, wr_ctrl;
        logic [1:0]       status_q, status_d, status_clr;
        logic [CNT_W-1:0] preset_q, preset_d, compare_q, compare_d, count_q, count_d;
        logic             irq_uf_q, irq_uf_d, irq_cmp_q, irq_cmp_d;
        logic [15:0]      pre16, cmp16, cnt16;
        logic             sel, ctrl_wr, reload, cmp_hit;
        logic [7:0]       cnt_h, rd_byte;

        assign sel     = wr_en && (ch_sel == 3'(ch));
        assign ctrl_wr = sel && (ofs == OFS_CTRL);
        assign reload  = ctrl_wr && wr_ctrl.reload;

        assign wr_ctrl.enable   = bus_data_in[CTRL_ENABLE];
        assign wr_ctrl.reload   = bus_data_in[CTRL_RELOAD];
        assign wr_ctrl.osc_sel  = bus_data_in[CTRL_OSC_SEL];
        assign wr_ctrl.one_shot = bus_data_in[CTRL_ONE_SHOT];
        assign wr_ctrl.chain    = bus_data_in[CTRL_CHAIN];
        assign wr_ctrl.prescale = bus_data_in[CTRL_PRESCALE_LSB +: 3];

        // 16-bit views; with CNT_W = 8 the H bytes read 0 and writes truncate away
        assign pre16 = 16'(preset_q);
        assign cmp16 = 16'(compare_q);
        assign cnt16 = 16'(count_q);

        assign chain_sel[ch] = (ch > 0) && ctrl_q.chain;
        assign base_tick[ch] = ctrl_q.osc_sel ? tick_osc2[ctrl_q.prescale]
                                              : tick_osc1[ctrl_q.prescale];
        // A CTRL write that disables or reloads the channel wins over this cycle's tick
        assign active[ch]    = ctrl_q.enable && !(ctrl_wr && (!wr_ctrl.enable || wr_ctrl.reload));
        assign cnt_zero[ch]  = (count_q == '0);
        assign cmp_hit       = tick_ev[ch] && (count_q == compare_q);
        assign status_clr    = (sel && (ofs == OFS_STATUS)) ? bus_data_in[1:0] : 2'b00;

        // Next state: CPU writes, reload strobe, then tick-driven count and flags
        always_comb begin
            ctrl_d    = ctrl_q;
            status_d  = (status_q & ~status_clr) | {cmp_hit, uf_ev[ch]};
            preset_d  = preset_q;
            compare_d = compare_q;
            count_d   = count_q;
            if (ctrl_wr) begin
                ctrl_d        = wr_ctrl;
                ctrl_d.reload = 1'b0;
            end else if (uf_ev[ch] && ctrl_q.one_shot) begin
                ctrl_d.enable = 1'b0;
            end
            if (sel) begin
                case (ofs)
                    OFS_PRE_L: preset_d  = CNT_W'({pre16[15:8], bus_data_in});
                    OFS_PRE_H: preset_d  = CNT_W'({bus_data_in, pre16[7:0]});
                    OFS_CMP_L: compare_d = CNT_W'({cmp16[15:8], bus_data_in});
                    OFS_CMP_H: compare_d = CNT_W'({bus_data_in, cmp16[7:0]});
                    default: ;
                endcase
            end
            if (reload || uf_ev[ch]) begin
                count_d = preset_q;
            end else if (tick_ev[ch]) begin
                count_d = count_q - CNT_W'(1);
            end
            // Pulses stretch until a CPU-enable cycle without a new event
            irq_uf_d  = uf_ev[ch] ? 1'b1 : (clk_ce_cpu ? 1'b0 : irq_uf_q);
            irq_cmp_d = cmp_hit   ? 1'b1 : (clk_ce_cpu ? 1'b0 : irq_cmp_q);
        end

        // Channel state registers
        always_ff @(posedge clk) begin
            if (reset) begin
                ctrl_q    <= '0;
                status_q  <= '0;
                preset_q  <= '0;
                compare_q <= '0;
                count_q   <= '0;
                irq_uf_q  <= 1'b0;
                irq_cmp_q <= 1'b0;
            end else begin
                ctrl_q    <= ctrl_d;
                status_q  <= status_d;
                preset_q  <= preset_d;
                compare_q <= compare_d;
                count_q   <= count_d;
                irq_uf_q  <= irq_uf_d;
                irq_cmp_q <= irq_cmp_d;
            end
        end

`ifdef MULTI_TIMER_SNAPSHOT_EN
        logic [7:0] snap_q;
        // Latch the high count byte whenever COUNT L is read
        always_ff @(posedge clk) begin
            if (reset) begin
                snap_q <= '0;
            end else if (rd_en && (ch_sel == 3'(ch)) && (ofs == OFS_CNT_L)) begin
                snap_q <= cnt16[15:8];
            end
        end
        assign cnt_h = snap_q;
`else
        assign cnt_h = cnt16[15:8];
`endif

        // Register readback for this channel
        always_comb begin
            rd_byte = 8'h00;
            case (ofs)
                OFS_CTRL:   rd_byte = ctrl_q;
                OFS_STATUS: rd_byte = {6'b000000, status_q};
                OFS_PRE_L:  rd_byte = pre16[7:0];
                OFS_PRE_H:  rd_byte = pre16[15:8];
                OFS_CMP_L:  rd_byte = cmp16[7:0];
                OFS_CMP_H:  rd_byte = cmp16[15:8];
                OFS_CNT_L:  rd_byte = cnt16[7:0];
                OFS_CNT_H:  rd_byte = cnt_h;
                default: ;
            endcase
        end

        assign rdata[ch]         = rd_byte;
        assign irq_underflow[ch] = irq_uf_q;
        assign irq_compare[ch]   = irq_cmp_q;
        assign tout[ch]          = ctrl_q.enable && (count_q >= compare_q);
    end

endmodule

// File: tb/tb_multi_timer.sv
// Directed bench for multi_timer (3 channels, 16-bit counters).
module tb_multi_timer;

    localparam logic [23:0] CH0 = 24'h002030;
    localparam logic [23:0] CH1 = 24'h002038;
    localparam logic [23:0] CH2 = 24'h002040;

    logic        clk, reset, clk_ce, clk_ce_cpu, rt_tick;
    logic        bus_write, bus_read;
    logic [23:0] bus_address_in;
    logic [7:0]  bus_data_in, bus_data_out;
    logic [2:0]  irq_underflow, irq_compare, tout;
    logic [7:0]  d;
    int          n_assert = 0;
    int          n_fail   = 0;

    multi_timer dut (
        .clk            (clk),
        .reset          (reset),
        .clk_ce         (clk_ce),
        .clk_ce_cpu     (clk_ce_cpu),
        .rt_tick        (rt_tick),
        .bus_write      (bus_write),
        .bus_read       (bus_read),
        .bus_address_in (bus_address_in),
        .bus_data_in    (bus_data_in),
        .bus_data_out   (bus_data_out),
        .irq_underflow  (irq_underflow),
        .irq_compare    (irq_compare),
        .tout           (tout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [23:0] a, input logic [7:0] v);
        bus_address_in = a;
        bus_data_in    = v;
        bus_write      = 1'b1;
        cycle();
        bus_write      = 1'b0;
    endtask

    task automatic rd(input logic [23:0] a, output logic [7:0] v);
        bus_address_in = a;
        bus_read       = 1'b1;
        #1;
        v = bus_data_out;
        cycle();
        bus_read       = 1'b0;
    endtask

    task automatic osc1_pulse();
        clk_ce = 1'b1;
        cycle();
        clk_ce = 1'b0;
    endtask

    task automatic rt_pulse();
        rt_tick = 1'b1;
        cycle();
        rt_tick = 1'b0;
    endtask

    initial begin
        reset = 1'b1; clk_ce = 1'b0; clk_ce_cpu = 1'b1; rt_tick = 1'b0;
        bus_write = 1'b0; bus_read = 1'b0; bus_address_in = '0; bus_data_in = '0;
        cycle(); cycle();
        reset = 1'b0;

        // Reset state
        chk("rst_irq_uf", 16'(irq_underflow), 16'h0);
        chk("rst_irq_cmp", 16'(irq_compare), 16'h0);
        chk("rst_tout", 16'(tout), 16'h0);
        rd(CH0, d);              chk("rst_ctrl0", 16'(d), 16'h00);
        rd(CH2 + 24'd7, d);      chk("rst_cnt_h2", 16'(d), 16'h00);

        // Register access, read-only COUNT, address misses
        wr(CH0 + 24'd2, 8'h34);
        wr(CH0 + 24'd3, 8'h12);
        rd(CH0 + 24'd2, d);      chk("pre_l", 16'(d), 16'h34);
        rd(CH0 + 24'd3, d);      chk("pre_h", 16'(d), 16'h12);
        rd(CH0 + 24'd6, d);      chk("cnt_after_pre", 16'(d), 16'h00);
        wr(CH0 + 24'd6, 8'h55);
        rd(CH0 + 24'd6, d);      chk("cnt_wr_ignored", 16'(d), 16'h00);
        wr(24'h002048, 8'hAA);
        rd(24'h002048, d);       chk("miss_hi", 16'(d), 16'h00);
        rd(24'h00202F, d);       chk("miss_lo", 16'(d), 16'h00);

        // Auto-reload on ch0, osc1 prescale 0 (tick every second clk_ce)
        wr(CH0 + 24'd2, 8'h03);
        wr(CH0 + 24'd3, 8'h00);
        wr(CH0, 8'h03);
        rd(CH0, d);              chk("ctrl_reload_reads0", 16'(d), 16'h01);
        rd(CH0 + 24'd6, d);      chk("reload_cnt", 16'(d), 16'h03);
        for (int k = 1; k <= 4; k++) begin
            osc1_pulse();
            osc1_pulse();
            chk($sformatf("ar_irq_uf_%0d", k), 16'(irq_underflow), (k == 4) ? 16'h1 : 16'h0);
            chk($sformatf("ar_irq_cmp_%0d", k), 16'(irq_compare), (k == 4) ? 16'h1 : 16'h0);
            rd(CH0 + 24'd6, d);
            chk($sformatf("ar_cnt_%0d", k), 16'(d), (k == 4) ? 16'h3 : 16'(3 - k));
        end
        chk("ar_irq_cleared", 16'(irq_underflow), 16'h0);
        chk("ar_tout", 16'(tout), 16'h1);
        rd(CH0 + 24'd1, d);      chk("status_both", 16'(d), 16'h03);
        wr(CH0 + 24'd1, 8'h01);
        rd(CH0 + 24'd1, d);      chk("status_w1c_uf", 16'(d), 16'h02);
        wr(CH0, 8'h00);

        // One-shot on ch1, osc2 prescale 0
        wr(CH1 + 24'd2, 8'h02);
        wr(CH1, 8'h0F);
        rd(CH1 + 24'd6, d);      chk("os_cnt0", 16'(d), 16'h02);
        for (int k = 1; k <= 3; k++) begin
            rt_pulse();
            chk($sformatf("os_irq_uf_%0d", k), 16'(irq_underflow), (k == 3) ? 16'h2 : 16'h0);
            rd(CH1 + 24'd6, d);
            chk($sformatf("os_cnt_%0d", k), 16'(d), (k == 3) ? 16'h2 : 16'(2 - k));
        end
        rd(CH1, d);              chk("os_enable_cleared", 16'(d), 16'h0C);
        for (int k = 1; k <= 2; k++) begin
            rt_pulse();
            chk($sformatf("os_quiet_uf_%0d", k), 16'(irq_underflow), 16'h0);
            chk($sformatf("os_quiet_cmp_%0d", k), 16'(irq_compare), 16'h0);
        end
        chk("os_tout", 16'(tout), 16'h0);

        // Chaining: ch1 counts ch0 underflows
        wr(CH0 + 24'd2, 8'h01);
        wr(CH0, 8'h07);
        wr(CH1 + 24'd2, 8'h00);
        wr(CH1, 8'h13);
        for (int k = 1; k <= 4; k++) begin
            rt_pulse();
            chk($sformatf("chain_irq_uf_%0d", k), 16'(irq_underflow),
                (k % 2 == 0) ? 16'h3 : 16'h0);
        end
        wr(CH0, 8'h00);
        wr(CH1, 8'h00);

        // Compare / PWM on ch2
        wr(CH2 + 24'd2, 8'h09);
        wr(CH2 + 24'd4, 8'h04);
        wr(CH2, 8'h07);
        chk("pwm_tout_start", 16'(tout), 16'h4);
        for (int n = 1; n <= 9; n++) begin
            rt_pulse();
            chk($sformatf("pwm_tout_%0d", n), 16'(tout), ((9 - n) >= 4) ? 16'h4 : 16'h0);
            chk($sformatf("pwm_irq_cmp_%0d", n), 16'(irq_compare),
                ((9 - n) == 3) ? 16'h4 : 16'h0);
            rd(CH2 + 24'd6, d);
            chk($sformatf("pwm_cnt_%0d", n), 16'(d), 16'(9 - n));
        end

        // Reload strobe in the same cycle as an underflow tick
        bus_address_in = CH2;
        bus_data_in    = 8'h07;
        bus_write      = 1'b1;
        rt_tick        = 1'b1;
        cycle();
        bus_write      = 1'b0;
        rt_tick        = 1'b0;
        chk("prio_no_irq_uf", 16'(irq_underflow), 16'h0);
        rd(CH2 + 24'd6, d);      chk("prio_cnt_preset", 16'(d), 16'h09);
        rd(CH2 + 24'd1, d);      chk("prio_status", 16'(d), 16'h02);

        // Disabling write suppresses a coincident tick
        bus_address_in = CH2;
        bus_data_in    = 8'h04;
        bus_write      = 1'b1;
        rt_tick        = 1'b1;
        cycle();
        bus_write      = 1'b0;
        rt_tick        = 1'b0;
        rd(CH2 + 24'd6, d);      chk("dis_cnt_held", 16'(d), 16'h09);
        chk("dis_tout", 16'(tout), 16'h0);

        // COUNT L/H read across a 0x0100 -> 0x00FF roll
        wr(CH0 + 24'd2, 8'h00);
        wr(CH0 + 24'd3, 8'h01);
        wr(CH0, 8'h07);
        rd(CH0 + 24'd6, d);      chk("roll_l", 16'(d), 16'h00);
        rt_pulse();
        rd(CH0 + 24'd7, d);
`ifdef MULTI_TIMER_SNAPSHOT_EN
        chk("roll_h_snapshot", 16'(d), 16'h01);
`else
        chk("roll_h_live", 16'(d), 16'h00);
`endif
        rd(CH0 + 24'd6, d);      chk("roll_l_after", 16'(d), 16'hFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/multi_timer.md
# multi_timer

Parametrised N-channel down-counting timer array for the Pokemon Mini SoC. It succeeds the fixed 2×8/1×16 timer, adding:
- per-channel one-shot/auto-reload mode
- channel chaining
- write-1-clear status flags
- coherent multi-byte count reads

It sits on the CPU byte bus beside the IRQ controller, which consumes its per-channel underflow and compare pulses, and feeds `tout` to the sound/IR logic.

## Interface
- `NUM_CH`, 3: number of channels, 1–8.
- `CNT_W`, 16: counter width, 8 or 16.
- `BASE_ADDR`, 24'h002030: first register address; each channel occupies 8 bytes at `BASE_ADDR + 8*ch`.
- `clk` in 1: system clock; all logic on its rising edge.
- `reset` in 1: synchronous, active-high.
- `clk_ce` in 1: timer-domain clock enable, which advances oscillator 1.
- `clk_ce_cpu` in 1: CPU bus-cycle enable.
- `rt_tick` in 1: single-`clk` pulse per 32768 Hz edge, already synchronised; advances oscillator 2.
- `bus_write` in 1: write strobe, sampled when `clk_ce_cpu`.
- `bus_read` in 1: read strobe, used only for snapshot capture.
- `bus_address_in` in 24: byte address.
- `bus_data_in` in 8: write data.
- `bus_data_out` out 8: combinational read data; 0 when the address misses.
- `irq_underflow` out `NUM_CH`: underflow pulse per channel.
- `irq_compare` out `NUM_CH`: compare-match pulse per channel.
- `tout` out `NUM_CH`: PWM output per channel.

## Operation
- Register offsets per channel:
  - +0 CTRL: [0] enable, [1] reload strobe (write-only, reads 0), [2] osc select (0 = osc1, 1 = osc2), [3] one-shot, [4] chain, [7:5] prescale.
  - +1 STATUS: [0] underflow flag, [1] compare flag; write 1 to clear.
  - +2/+3 PRESET L/H.
  - +4/+5 COMPARE L/H.
  - +6/+7 COUNT L/H, read-only.
- When `CNT_W = 8`, the H bytes read 0 and ignore writes.
- Oscillator 1 is a shared 12-bit free-running counter incremented on `clk_ce`. For prescale p, the tick is `clk_ce` AND the low k bits are all ones, with k = 1, 3, 5, 6, 7, 8, 10, 12 for p = 0..7.
- Oscillator 2 is a shared 7-bit counter incremented on `rt_tick`. For prescale p, the tick is `rt_tick` AND the low p bits are all ones; p = 0 ticks on every `rt_tick`.
- Chaining: if chain = 1 and ch > 0, the channel ticks on channel ch-1's underflow event in the same cycle, and the prescale/osc fields are ignored. Chain is ignored on channel 0.
- On a tick with enable = 1:
  - If count == compare: pulse `irq_compare` and set the compare flag.
  - If count == 0: underflow. Pulse `irq_underflow`, set the underflow flag, and load count = PRESET. If one-shot, also clear enable.
  - Otherwise count decrements by 1.
- `tout[ch]` = enable AND (count >= compare), computed as an unsigned `CNT_W`-bit comparison.
- IRQ pulses are held high until the next `clk_ce_cpu` cycle that has no new event, so the CPU-rate IRQ controller always samples them.
- Priority per channel each cycle: `reset` > reload strobe (count = PRESET, no IRQ) > CPU write to CTRL (a write that clears enable suppresses that cycle's tick) > tick.
- PRESET writes while running do not affect count until the next reload or underflow.
- Writes to COUNT are ignored.
- Addresses outside `BASE_ADDR .. BASE_ADDR + 8*NUM_CH - 1` are ignored on write and read 0.

## Timing
- Register write lands on the `clk` edge where `clk_ce_cpu && bus_write`; the new value is visible the following cycle.
- Reload strobe takes 1 cycle: count equals PRESET on the cycle after the write.
- The count update and IRQ pulse appear on the edge after the tick cycle.
- A chained channel updates on the same edge as its source channel's underflow; there is no extra latency per chain stage.
- Reset values:
  - All registers, both oscillators and all counts: 0.
  - `irq_underflow`, `irq_compare`, `tout`: 0.
  - `bus_data_out`: 0, since registers are 0.
- PRESET = 0 with a channel enabled gives an underflow on every tick.
- Both oscillator counters wrap silently.

## Configuration
- `MULTI_TIMER_SNAPSHOT_EN` defined:
  - A read of COUNT L while `bus_read && clk_ce_cpu` captures count[15:8] into a per-channel snapshot.
  - COUNT H then returns the snapshot, giving a coherent 16-bit read.
  - Snapshot resets to 0.
- `MULTI_TIMER_SNAPSHOT_EN` undefined: COUNT H returns live count[15:8].

## Structure
- Package `multi_timer_pkg`:
  - register offset constants: `OFS_CTRL`, `OFS_STATUS`, `OFS_PRE_L/H`, `OFS_CMP_L/H`, `OFS_CNT_L/H`
  - CTRL bit-index constants
  - `tmr_ctrl_t` packed struct
  - the osc1 prescale width table
- Sub-module `multi_timer_prescaler`: holds both oscillator counters and outputs an 8-bit tick vector per oscillator. Channels select from these vectors with their prescale field.
- Channels are built with a generate loop inside `multi_timer`.

## Test plan
- Auto-reload: ch0 PRESET = 3, osc1 p = 0, enable → count 3,2,1,0,3; `irq_underflow[0]` once per 4 ticks (every 8 `clk_ce`).
- One-shot: ch1 PRESET = 2, one-shot = 1 → exactly one underflow; enable reads 0 afterwards; no further IRQs.
- Chaining: ch0 PRESET = 1, ch1 chain = 1 with PRESET = 0 → ch1 underflows on every second ch0 tick, on the same edge as ch0's underflow.
- Compare/PWM: PRESET = 9, COMPARE = 4, osc2 p = 0 → `tout` high for counts 9..4 and low for 3..0; `irq_compare` at count 4.
- Status and priority: reload strobe written in the same cycle as an underflow tick → count = PRESET with no IRQ. Writing 0x01 to STATUS clears only the underflow flag.
- Snapshot with `MULTI_TIMER_SNAPSHOT_EN`: count rolls 0x0100 → 0x00FF between reading L and reading H → the L then H reads return 0x00 then 0x01.
